unified_mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences each access as a req/ack transaction on the memory side.
- Produces per-stage completion pulses and stall levels. The pipeline control logic combines these with the load-use stall (PCWrite / IF_ID_Write gating).
- Data accesses have priority, because the MEM-stage instruction is older.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/ack_watchdog.sv | 34 +++
 rtl/unified_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline memory-side blocks: arbiter state
// encoding, bus-owner encoding and default bus widths.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Arbiter FSM encoding, kept as plain constants for legacy compatibility
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Which pipeline stage currently owns the memory port
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/ack_watchdog.sv
// Counts cycles spent waiting for a memory acknowledge. 'expired' is high
// while the count sits at its last value, so the owner can abort the access
// in the same cycle instead of one cycle late.
module ack_watchdog #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Wait counter: clear wins over counting so a fresh access starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction
// fetch and the MEM stage. Data accesses win because the MEM-stage
// instruction is older. Each access is a req/ack transaction on the memory
// side; a watchdog aborts accesses whose ack never arrives so the pipeline
// cannot deadlock.
module unified_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  logic [1:0]        state_r;
  owner_t            owner_r;
  logic              flush_pend_r;
  logic              wd_clear_s;
  logic              wd_en_s;
  logic              wd_expired_s;
  logic              busy_end_s;
  logic [DATA_W-1:0] resp_data_s;

  // Watchdog runs only while waiting in BUSY; it is held at zero elsewhere
  always_comb begin
    wd_clear_s = 1'b1;
    wd_en_s    = 1'b0;
    if (state_r == ST_BUSY) begin
      wd_clear_s = 1'b0;
      wd_en_s    = ~mem_ack;
    end else begin
      wd_clear_s = 1'b1;
      wd_en_s    = 1'b0;
    end
  end

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear_s),
    .count_en (wd_en_s),
    .expired  (wd_expired_s)
  );

  // A BUSY access ends on ack, or on timeout; a late ack beats the timeout
  always_comb begin
    busy_end_s  = 1'b0;
    resp_data_s = '0;
    if (state_r == ST_BUSY) begin
      busy_end_s = mem_ack | wd_expired_s;
    end else begin
      busy_end_s = 1'b0;
    end
    if (mem_ack) begin
      resp_data_s = mem_rdata;
    end else begin
      resp_data_s = '0;
    end
  end

  // Arbitration FSM: grant in IDLE, hold the bus in BUSY, pulse ready in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dm_req) begin
            owner_r   <= OWN_DATA;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_req   <= 1'b1;
            state_r   <= ST_BUSY;
          end else if (if_req && !if_flush) begin
            owner_r   <= OWN_FETCH;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (busy_end_s) begin
            mem_req <= 1'b0;
            state_r <= ST_RESP;
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
            case (owner_r)
              OWN_FETCH: begin
                // A flush seen in the ack cycle itself also cancels the fetch
                if (!flush_pend_r && !if_flush) begin
                  if_rdata <= resp_data_s;
                  if_ready <= 1'b1;
                end
              end
              OWN_DATA: begin
                dm_rdata <= resp_data_s;
                dm_ready <= 1'b1;
              end
              default: begin
                state_r <= ST_RESP;
              end
            endcase
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
        end
        default: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Remember a flush that hits an in-flight fetch; forget it on return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_r <= 1'b0;
    end else if (state_r == ST_RESP) begin
      flush_pend_r <= 1'b0;
    end else if ((state_r == ST_BUSY) && (owner_r == OWN_FETCH) && if_flush) begin
      flush_pend_r <= 1'b1;
    end else begin
      flush_pend_r <= flush_pend_r;
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a behavioural memory with a
// per-transaction ack delay, a transaction log, and latency/data expectations
// derived from the request -> grant -> ack -> ready timeline.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_ready, dm_ready, stall_if, stall_mem;
  logic          mem_req, mem_we, mem_ack, bus_err;
  logic [AW-1:0] mem_addr;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            start_cyc;
    int            ack_cyc;
    int            req_cycles;
  } txn_t;

  txn_t          txn_q[$];
  int            delay_q[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] exp_if;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  // Behavioural memory: acks after a per-transaction number of req cycles
  initial begin
    txn_t cur;
    int   busy_cnt;
    int   cur_delay;
    mem_ack = 1'b0; mem_rdata = '0; busy_cnt = 0; cur_delay = 1;
    cur = '{we: 1'b0, addr: '0, wdata: '0, start_cyc: 0, ack_cyc: 0, req_cycles: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0; busy_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; busy_cnt = 0;
      end else if (mem_req) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
          cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
          cur.start_cyc = cyc;
        end
        if (busy_cnt == cur_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_read(mem_addr);
          end
          cur.ack_cyc = cyc; cur.req_cycles = busy_cnt;
          txn_q.push_back(cur);
        end
      end else begin
        if (busy_cnt != 0) begin
          cur.ack_cyc = -1; cur.req_cycles = busy_cnt;
          txn_q.push_back(cur);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Tick until the selected ready pulses; report latency and stall observations
  task automatic wait_done(input bit data, input int limit, output int n,
                           output int sif0, output int smem0, output int other);
    n = -1; sif0 = 0; smem0 = 0; other = 0;
    for (int t = 1; t <= limit; t++) begin
      tick();
      if (!stall_if) sif0++;
      if (!stall_mem) smem0++;
      if (data ? if_ready : dm_ready) other++;
      if (data ? dm_ready : if_ready) begin
        n = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    total++; if ({mem_req, mem_we, if_ready, dm_ready, bus_err, stall_if, stall_mem} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_we, if_ready, dm_ready, bus_err, stall_if, stall_mem});
    end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata});
    end
    total++; if ({if_rdata, dm_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata});
    end
    rst = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0) begin
      bad++; $display("FAIL idle_no_req got=%b exp=0", mem_req);
    end
    exp_if = '0;
  endtask

  task automatic test_fetch();
    int n, s0, m0, o, base, d;
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a = 32'h0000_0040; d = 2; mem_model[a] = 32'h8C22_0004;
      end else begin
        a = 32'h0000_4000 + ($urandom_range(0, 255) << 2); d = $urandom_range(1, 6);
        mem_model[a] = $urandom;
      end
      base = txn_q.size();
      delay_q.push_back(d);
      if_req = 1'b1; if_addr = a;
      wait_done(1'b0, 30, n, s0, m0, o);
      if_req = 1'b0;
      total++; if (n !== d + 1) begin
        bad++; $display("FAIL fetch_latency i=%0d got=%0d exp=%0d", i, n, d + 1);
      end
      total++; if (if_rdata !== mem_model[a]) begin
        bad++; $display("FAIL fetch_data i=%0d got=%h exp=%h", i, if_rdata, mem_model[a]);
      end
      exp_if = mem_model[a];
      total++; if (s0 !== 1 || o !== 0) begin
        bad++; $display("FAIL fetch_stall i=%0d stall_if_low=%0d dm_ready=%0d exp=1,0", i, s0, o);
      end
      tick();
      total++; if (if_ready !== 1'b0) begin
        bad++; $display("FAIL fetch_pulse_width i=%0d got=%b exp=0", i, if_ready);
      end
      total++; if (txn_q.size() != base + 1 || txn_q[base].addr !== a || txn_q[base].we !== 1'b0) begin
        bad++; $display("FAIL fetch_bus i=%0d n=%0d exp addr=%h we=0", i, txn_q.size() - base, a);
      end
    end
  endtask

  task automatic test_priority();
    int n, s0, m0, o, base, d1, d2;
    logic [AW-1:0] da, fa;
    logic [DW-1:0] wd;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        da = 32'h0000_1000; wd = 32'hDEAD_BEEF;
      end else begin
        da = 32'h0000_8000 + ($urandom_range(0, 255) << 2); wd = $urandom;
      end
      fa = 32'h0000_0100 + ($urandom_range(0, 63) << 2);
      mem_model[fa] = $urandom;
      d1 = $urandom_range(1, 5); d2 = $urandom_range(1, 5);
      base = txn_q.size();
      delay_q.push_back(d1); delay_q.push_back(d2);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = da; dm_wdata = wd;
      if_req = 1'b1; if_addr = fa;
      wait_done(1'b1, 30, n, s0, m0, o);
      dm_req = 1'b0; dm_we = 1'b0;
      total++; if (n !== d1 + 1 || s0 !== 0 || o !== 0) begin
        bad++; $display("FAIL prio_data i=%0d lat=%0d stall_if_low=%0d if_ready=%0d exp=%0d,0,0", i, n, s0, o, d1 + 1);
      end
      wait_done(1'b0, 30, n, s0, m0, o);
      if_req = 1'b0;
      total++; if (n !== d2 + 2 || s0 !== 1) begin
        bad++; $display("FAIL prio_fetch i=%0d lat=%0d stall_if_low=%0d exp=%0d,1", i, n, s0, d2 + 2);
      end
      total++; if (if_rdata !== mem_model[fa]) begin
        bad++; $display("FAIL prio_fetch_data i=%0d got=%h exp=%h", i, if_rdata, mem_model[fa]);
      end
      exp_if = mem_model[fa];
      tick();
      total++; if (txn_q.size() != base + 2 || txn_q[base].we !== 1'b1 || txn_q[base].addr !== da
                   || txn_q[base].wdata !== wd || txn_q[base + 1].we !== 1'b0 || txn_q[base + 1].addr !== fa) begin
        bad++; $display("FAIL prio_order i=%0d txns=%0d exp first store %h/%h then fetch %h", i, txn_q.size() - base, da, wd, fa);
      end
    end
  endtask

  task automatic test_flush();
    int n, base, d, d2, f, extra;
    logic [AW-1:0] a, b;
    for (int i = 0; i < 5; i++) begin
      a = 32'h0000_2000 + ($urandom_range(0, 63) << 2);
      b = 32'h0000_3000 + ($urandom_range(0, 63) << 2);
      mem_model[a] = $urandom; mem_model[b] = $urandom;
      d = $urandom_range(2, 5); d2 = $urandom_range(1, 4); f = $urandom_range(1, d);
      base = txn_q.size();
      delay_q.push_back(d); delay_q.push_back(d2);
      if_req = 1'b1; if_addr = a;
      n = -1; extra = 0;
      for (int t = 1; t <= 40; t++) begin
        tick();
        if (t == d + 2) begin
          total++; if (if_rdata !== exp_if) begin
            bad++; $display("FAIL flush_rdata_kept i=%0d got=%h exp=%h", i, if_rdata, exp_if);
          end
        end
        if (if_ready) begin
          if (t < d + 2) extra++;
          n = t;
          break;
        end
        if (t == f) begin if_flush = 1'b1; if_addr = b; end
        if (t == f + 1) if_flush = 1'b0;
      end
      if_req = 1'b0; if_flush = 1'b0;
      total++; if (extra !== 0 || n !== d + d2 + 3) begin
        bad++; $display("FAIL flush_ready i=%0d early=%0d lat=%0d exp=0,%0d", i, extra, n, d + d2 + 3);
      end
      total++; if (if_rdata !== mem_model[b]) begin
        bad++; $display("FAIL flush_redirect_data i=%0d got=%h exp=%h", i, if_rdata, mem_model[b]);
      end
      exp_if = mem_model[b];
      tick();
      total++; if (txn_q.size() != base + 2 || txn_q[base].addr !== a || txn_q[base + 1].addr !== b
                   || txn_q[base + 1].start_cyc - txn_q[base].ack_cyc != 3) begin
        bad++; $display("FAIL flush_bus i=%0d txns=%0d exp 2 with idle gap", i, txn_q.size() - base);
      end
    end
    // Flush coinciding with the request in IDLE delays the grant by one cycle
    a = 32'h0000_0200; mem_model[a] = 32'h1357_9BDF; d = 2;
    delay_q.push_back(d);
    if_req = 1'b1; if_addr = a; if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    wait_done(1'b0, 30, n, extra, f, d2);
    if_req = 1'b0;
    total++; if (n + 1 !== d + 2 || if_rdata !== 32'h1357_9BDF) begin
      bad++; $display("FAIL flush_idle lat=%0d data=%h exp=%0d,13579bdf", n + 1, if_rdata, d + 2);
    end
    exp_if = 32'h1357_9BDF;
    tick();
  endtask

  task automatic test_timeout();
    int n, s0, m0, o, base;
    // Ack arriving in the last allowed BUSY cycle still completes normally
    mem_model[32'h2000_0000] = 32'hCAFE_0001;
    delay_q.push_back(TO);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000_0000;
    wait_done(1'b1, 30, n, s0, m0, o);
    dm_req = 1'b0;
    total++; if (n !== TO + 1 || dm_rdata !== 32'hCAFE_0001 || bus_err !== 1'b0) begin
      bad++; $display("FAIL late_ack lat=%0d data=%h err=%b exp=%0d,cafe0001,0", n, dm_rdata, bus_err, TO + 1);
    end
    tick();
    base = txn_q.size();
    delay_q.push_back(-1);
    dm_req = 1'b1; dm_addr = 32'h2000_0004;
    wait_done(1'b1, 30, n, s0, m0, o);
    dm_req = 1'b0;
    total++; if (n !== TO + 1 || dm_rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_ready lat=%0d data=%h exp=%0d,0", n, dm_rdata, TO + 1);
    end
    total++; if (bus_err !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_err err=%b req=%b exp=1,0", bus_err, mem_req);
    end
    tick();
    total++; if (txn_q.size() != base + 1 || txn_q[base].req_cycles != TO || txn_q[base].ack_cyc != -1) begin
      bad++; $display("FAIL timeout_req_len got=%0d exp=%0d", txn_q[txn_q.size() - 1].req_cycles, TO);
    end
    mem_model[32'h0000_0300] = 32'h0BAD_F00D;
    delay_q.push_back(1);
    if_req = 1'b1; if_addr = 32'h0000_0300;
    wait_done(1'b0, 30, n, s0, m0, o);
    if_req = 1'b0;
    total++; if (n !== 2 || if_rdata !== 32'h0BAD_F00D || bus_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky lat=%0d data=%h err=%b exp=2,0badf00d,1", n, if_rdata, bus_err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int n, s0, m0, o;
    delay_q.push_back(6);
    if_req = 1'b1; if_addr = 32'h0000_0400;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_req, if_ready, dm_ready, bus_err} !== 4'b0 || if_rdata !== 32'h0) begin
      bad++; $display("FAIL async_reset got=%b rdata=%h exp=0", {mem_req, if_ready, dm_ready, bus_err}, if_rdata);
    end
    if_req = 1'b0;
    tick(); tick();
    delay_q.delete();
    rst = 1'b0;
    tick();
    mem_model[32'h0000_0500] = 32'h2468_ACE0;
    delay_q.push_back(2);
    if_req = 1'b1; if_addr = 32'h0000_0500;
    wait_done(1'b0, 30, n, s0, m0, o);
    if_req = 1'b0;
    total++; if (n !== 3 || if_rdata !== 32'h2468_ACE0) begin
      bad++; $display("FAIL post_reset_fetch lat=%0d data=%h exp=3,2468ace0", n, if_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, s0, m0, o, base, d1, d2;
    logic [AW-1:0] x, y;
    logic [DW-1:0] v1, v2;
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? 32'h0000_1000 : 32'h0000_6000 + ($urandom_range(0, 127) << 3);
      d1 = $urandom_range(1, 4); d2 = $urandom_range(1, 4);
      base = txn_q.size();
      delay_q.push_back(d1); delay_q.push_back(d2);
      dm_req = 1'b1;
      if (i < 2) begin
        // Load followed by load of the next word
        y = x + 32'd4; v1 = $urandom; v2 = $urandom;
        if (i == 0) v1 = 32'hDEAD_BEEF; else mem_model[x] = v1;
        mem_model[y] = v2;
        dm_we = 1'b0; dm_addr = x;
      end else begin
        // Store followed by a load of the stored word
        y = x; v1 = $urandom; v2 = v1;
        dm_we = 1'b1; dm_addr = x; dm_wdata = v1;
      end
      wait_done(1'b1, 30, n, s0, m0, o);
      total++; if (n !== d1 + 1 || m0 !== 1 || (i < 2 && dm_rdata !== v1)) begin
        bad++; $display("FAIL b2b_first i=%0d lat=%0d stall_mem_low=%0d data=%h exp=%0d,1,%h", i, n, m0, dm_rdata, d1 + 1, v1);
      end
      dm_we = 1'b0; dm_addr = y;
      wait_done(1'b1, 30, n, s0, m0, o);
      dm_req = 1'b0;
      total++; if (n !== d2 + 2 || dm_rdata !== v2) begin
        bad++; $display("FAIL b2b_second i=%0d lat=%0d data=%h exp=%0d,%h", i, n, dm_rdata, d2 + 2, v2);
      end
      tick();
      total++; if (txn_q.size() != base + 2 || txn_q[base + 1].addr !== y
                   || txn_q[base + 1].start_cyc - txn_q[base].ack_cyc != 3) begin
        bad++; $display("FAIL b2b_gap i=%0d txns=%0d exp 2 with one idle cycle", i, txn_q.size() - base);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not complete");
    $fatal(1, "time limit");
  end

endmodule
